// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for a 16-bit core.
//
// Two-state engine: FETCH issues a read at mem_addr and waits for mem_ack;
// HOLD presents the captured instruction to decode and waits for inst_ready.
// A redirect from execute may arrive at any time. While a read is in flight,
// the redirect is remembered through a kill flag, and the returning word is
// thrown away.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   mem_req/mem_addr  instruction read request and its byte address (bit 0 = 0)
//   mem_ack/mem_rdata read completion and returned instruction word
//   redirect_valid/pc PC change from execute (bit 0 of target ignored)
//   inst_valid/ready  handshake with decode; inst_valid comes from state only
//   opcode,rd,ra,rb   instruction fields [15:12],[11:8],[7:4],[3:0]
//   imm8              instruction field [7:0]
//   inst_pc           address the held instruction was fetched from
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [7:0]  imm8,
    output logic [15:0] inst_pc
);

    localparam logic [15:0] ResetAddr = {RESET_PC[15:1], 1'b0};

    typedef enum logic {StFetch, StHold} state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_pc, w_pc_d;        // next architectural fetch address
    logic [15:0] r_addr, w_addr_d;    // address currently presented to memory
    logic        r_kill, w_kill_d;    // in-flight read must be discarded
    logic        r_pend;              // last cycle had a request still unanswered
    logic [15:0] r_word, w_word_d;
    logic [15:0] r_inst_pc, w_inst_pc_d;
    logic [15:0] w_target;
    logic        w_mem_req;

    assign w_target = {redirect_pc[15:1], 1'b0};

    // Request is suppressed while reset is asserted.
    assign w_mem_req  = (r_state == StFetch) && rst_n;
    assign mem_req    = w_mem_req;
    assign mem_addr   = r_addr;
    assign inst_valid = (r_state == StHold);
    assign opcode     = r_word[15:12];
    assign rd         = r_word[11:8];
    assign ra         = r_word[7:4];
    assign rb         = r_word[3:0];
    assign imm8       = r_word[7:0];
    assign inst_pc    = r_inst_pc;

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_addr_d    = r_addr;
        w_kill_d    = r_kill;
        w_word_d    = r_word;
        w_inst_pc_d = r_inst_pc;
        unique case (r_state)
            StFetch: begin
                if (mem_ack) begin
                    if (r_kill || redirect_valid) begin
                        // Drop the word; newest redirect wins over a latched one.
                        w_kill_d = 1'b0;
                        w_pc_d   = redirect_valid ? w_target : r_pc;
                        w_addr_d = redirect_valid ? w_target : r_pc;
                    end else begin
                        w_word_d    = mem_rdata;
                        w_inst_pc_d = r_addr;
                        w_pc_d      = r_addr + 16'd2;
                        w_state_d   = StHold;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until the outstanding read returns.
                    w_kill_d = 1'b1;
                    w_pc_d   = w_target;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    // Covers both a dropped and a simultaneously accepted instruction.
                    w_pc_d    = w_target;
                    w_addr_d  = w_target;
                    w_state_d = StFetch;
                end else if (inst_ready) begin
                    w_addr_d  = r_pc;
                    w_state_d = StFetch;
                end
            end
            default: w_state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        r_pend <= w_mem_req & ~mem_ack;
        if (!rst_n) begin
            r_state   <= StFetch;
            r_pc      <= ResetAddr;
            r_addr    <= ResetAddr;
            r_word    <= 16'h0000;
            r_inst_pc <= 16'h0000;
            // A read left unanswered at reset may still be acked after release;
            // r_kill carries that across multi-cycle resets.
            r_kill    <= (r_pend | r_kill) & ~mem_ack;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_addr    <= w_addr_d;
            r_word    <= w_word_d;
            r_inst_pc <= w_inst_pc_d;
            r_kill    <= w_kill_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [3:0]  opcode, rd, ra, rb;
    logic [7:0]  imm8;
    logic [15:0] inst_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .opcode         (opcode),
        .rd             (rd),
        .ra             (ra),
        .rb             (rb),
        .imm8           (imm8),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Held instruction must be the word stored at pc, split into its fields.
    task automatic chk_inst(input string tag, input logic [15:0] pc);
        logic [15:0] w;
        w = mem_word(pc);
        chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
        chk({tag, "_op"}, 32'(opcode), 32'(w[15:12]));
        chk({tag, "_rd"}, 32'(rd), 32'(w[11:8]));
        chk({tag, "_ra"}, 32'(ra), 32'(w[7:4]));
        chk({tag, "_rb"}, 32'(rb), 32'(w[3:0]));
        chk({tag, "_imm"}, 32'(imm8), 32'(w[7:0]));
    endtask

    initial begin
        logic [15:0] exp_pc, prev_addr;
        logic        prev_req, prev_ack;
        logic [31:0] snap;
        int          xfers;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fields", {opcode, rd, ra, rb, 16'h0}, 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'h0000);
        chk("post_rst_valid", 32'(inst_valid), 32'd0);

        // First fetch returns 16'hC1A5.
        mem_ack = 1'b1;
        mem_rdata = 16'hC1A5;
        tick();
        mem_ack = 1'b0;
        chk("c1a5_valid", 32'(inst_valid), 32'd1);
        chk("c1a5_fields", {opcode, rd, ra, rb, imm8, 8'h00}, 32'hC1A5A500);
        chk("c1a5_inst_pc", 32'(inst_pc), 32'h0000);
        chk("c1a5_req", 32'(mem_req), 32'd0);

        // Stall decode for 5 cycles; a stray ack in HOLD must be ignored.
        snap = {opcode, rd, ra, rb, imm8, 8'h00};
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 2);
            mem_rdata = 16'hFFFF;
            tick();
            chk("stall_fields", {opcode, rd, ra, rb, imm8, 8'h00}, snap);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("accept_valid", 32'(inst_valid), 32'd0);
        chk("accept_req", 32'(mem_req), 32'd1);
        chk("accept_addr", 32'(mem_addr), 32'h0002);

        // Redirect two cycles before the ack: stale word dropped.
        redirect_valid = 1'b1;
        redirect_pc = 16'h1235;
        tick();
        redirect_valid = 1'b0;
        chk("kill_addr_hold", 32'(mem_addr), 32'h0002);
        tick();
        chk("kill_addr_hold2", 32'(mem_addr), 32'h0002);
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h0002);
        tick();
        mem_ack = 1'b0;
        chk("kill_valid", 32'(inst_valid), 32'd0);
        chk("kill_req", 32'(mem_req), 32'd1);
        chk("kill_new_addr", 32'(mem_addr), 32'h1234);
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h1234);
        tick();
        mem_ack = 1'b0;
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk_inst("redir", 16'h1234);

        // Accept and redirect in the same cycle.
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("xfer_redir_valid", 32'(inst_valid), 32'd0);
        chk("xfer_redir_addr", 32'(mem_addr), 32'h0040);

        // Redirect together with ack: word dropped, target (bit 0 cleared) issued.
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h0040);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        redirect_valid = 1'b0;
        chk("same_cyc_valid", 32'(inst_valid), 32'd0);
        chk("same_cyc_addr", 32'(mem_addr), 32'hFFFE);
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'hFFFE);
        tick();
        mem_ack = 1'b0;
        chk_inst("wrap", 16'hFFFE);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wrap_addr", 32'(mem_addr), 32'h0000);

        // Reset while holding an instruction.
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h0000);
        tick();
        mem_ack = 1'b0;
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("hold_rst_valid", 32'(inst_valid), 32'd0);
        chk("hold_rst_req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("hold_rst_addr", 32'(mem_addr), 32'h0000);
        chk("hold_rst_req2", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h0000);
        tick();
        mem_ack = 1'b0;
        chk("no_kill_valid", 32'(inst_valid), 32'd1);
        chk_inst("no_kill", 16'h0000);

        // Reset with a read outstanding: first ack after release is stale.
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        chk("pend_addr", 32'(mem_addr), 32'h0002);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        mem_rdata = mem_word(16'h0002);
        tick();
        chk("stale_valid", 32'(inst_valid), 32'd0);
        chk("stale_addr", 32'(mem_addr), 32'h0000);
        mem_rdata = mem_word(16'h0000);
        tick();
        mem_ack = 1'b0;
        chk_inst("after_stale", 16'h0000);
        exp_pc = 16'h0000;

        // Random traffic against the instruction-stream model.
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = 16'h0000;
        xfers = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_req && !prev_ack) begin
                chk("req_held", 32'(mem_req), 32'd1);
                chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            end
            mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = mem_req ? mem_word(mem_addr) : 16'($urandom);
            inst_ready = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            if (inst_valid && inst_ready) begin
                chk_inst("rand", exp_pc);
                xfers++;
                exp_pc = redirect_valid ? {redirect_pc[15:1], 1'b0} : exp_pc + 16'd2;
            end else if (redirect_valid) begin
                exp_pc = {redirect_pc[15:1], 1'b0};
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
            prev_addr = mem_addr;
            tick();
        end
        chk("rand_progress", 32'(xfers > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
